seq_pattern_gen: RTL and testbench
==================================

// Module: seq_pattern_gen
// PURPOSE
//  Testbench/formal stimulus generator: plays a character-coded waveform string, one char per clock.
//  Drives a 1-bit signal from a string such as "_---__-".
//  Used to script reset, inputs and toggles for property checks (assert/cover) without hand-written FSMs.
//  Synthesizable; PATTERN is fixed at elaboration.
// PARAMETERS
//  PATTERN  "_-"            waveform string; leftmost char = first cycle; '_'/'0' -> 0, '-'/'1' -> 1
//  LEN      $bits(PATTERN)/8 localparam, number of chars (>=1)
//  IW       max(1,$clog2(LEN)) localparam, index width
// PORTS
//  clk   in   1   sampling clock, all state on posedge
//  rst   in   1   asynchronous, active-high reset
//  out   out  1   current pattern bit (registered)
//  done  out  1   high while the last pattern char is being driven
//  idx   out  IW  index of char currently on out (0 = leftmost)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Char i occupies bits [8*(LEN-i)-1 -: 8] of PATTERN (SV literal packing, leftmost char in MSBs).
//  - Decode per char: 8'h5F '_' or 8'h30 '0' -> 0; 8'h2D '-' or 8'h31 '1' -> 1.
//  - Any other char, or LEN==0: elaboration-time $error; such a char decodes to 0 if elaboration continues.
//  - Decode table built once at elaboration into a LEN-bit vector bits[0..LEN-1]; no runtime string ops.
//  - Reset (async assert): idx=0, out=bits[0], done=(LEN==1); takes effect immediately, no clock needed.
//  - Reset release: the first posedge after rst falls advances to idx=1.
//    Char 0 covers the reset cycle(s) plus the cycle up to that edge.
//  - Each posedge with rst=0 and idx<LEN-1: idx<=idx+1, out<=bits[idx+1].
//  - Latency: out changes only on posedge (or rst assert); no combinational path from inputs.
//  - done = (idx==LEN-1), derived from registered idx, so it is glitch-free.
//  - End of pattern (macro absent): idx saturates at LEN-1; out holds bits[LEN-1]; done stays 1 until rst.
//  - LEN==1: out constant bits[0], done=1 permanently, idx=0.
//  - Reset mid-pattern: immediate return to idx=0 and out=bits[0]; the pattern restarts from the left.
//  - Reset held: all outputs stay at reset values regardless of clk.
//  - No X propagation: every register is reset.
// CONFIGURATION
//  SEQ_PATTERN_LOOP_EN defined:
//   - at idx==LEN-1 the next posedge wraps: idx<=0, out<=bits[0], and the pattern repeats forever.
//   - done is high for exactly one cycle per pass (the last char), e.g. every LEN cycles.
//  Undefined (default): saturate-and-hold as above, no wrap.
// TESTING
//  1 PATTERN="_---", rst 1 then 0 -> out 0,1,1,1 on successive cycles, then 1 held; done high from cycle 3 on.
//  2 PATTERN="_-_-_-", no loop -> out alternates 0,1,0,1,0,1, then holds 1; idx saturates at 5.
//  3 PATTERN="-------____________-" -> 7 cycles of 1, 12 cycles of 0, then 1 from cycle 19 onward.
//  4 Reset asserted asynchronously at idx=4 between edges -> out=bits[0] and idx=0 before the next posedge.
//  5 SEQ_PATTERN_LOOP_EN, PATTERN="_-" -> out 0,1,0,1,... indefinitely; done=1 on every odd cycle.
//  6 PATTERN="-" (LEN=1) -> out=1, done=1, idx=0 from reset onward; PATTERN="_x" -> elaboration $error.

Source files
------------

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - output bundle of the pattern generator (bit, last-char flag, char index).
// IW must match the index width the generator derives from its PATTERN.
interface seq_pattern_gen_if #(
  parameter int IW = 1
);
  logic          out;
  logic          done;
  logic [IW-1:0] idx;

  modport master (output out, output done, output idx);
  modport slave  (input  out, input  done, input  idx);
endinterface

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - plays a character-coded waveform string, one char per clock.
// Optional macro SEQ_PATTERN_LOOP_EN: wrap to the first char after the last instead of holding.
module seq_pattern_gen #(
  parameter PATTERN = "_-"
) (
  input  logic               clk,
  input  logic               rst,
  seq_pattern_gen_if.master  pg
);

  localparam int LEN   = $bits(PATTERN) / 8;
  localparam int LEN_S = (LEN < 1) ? 1 : LEN;
  localparam int IW    = (LEN_S <= 2) ? 1 : $clog2(LEN_S);
  localparam int DEPTH = 1 << IW;
  localparam logic [IW-1:0] LAST = IW'(LEN_S - 1);

  // Char i sits in the MSB-first packing of the literal; bits beyond LEN are padding.
  function automatic logic [DEPTH-1:0] decode_pattern();
    logic [DEPTH-1:0] v;
    logic [7:0]       c;
    v = '0;
    for (int i = 0; i < LEN; i++) begin
      c = PATTERN[8*(LEN-i)-1 -: 8];
      v[i] = (c == 8'h2D) || (c == 8'h31);
    end
    return v;
  endfunction

  localparam logic [DEPTH-1:0] BITS = decode_pattern();

  if (LEN < 1) begin : g_len_err
    $error("seq_pattern_gen: PATTERN must contain at least one char");
  end

  for (genvar gi = 0; gi < LEN; gi++) begin : g_char_chk
    localparam logic [7:0] CH = PATTERN[8*(LEN-gi)-1 -: 8];
    if (!(CH == 8'h5F || CH == 8'h30 || CH == 8'h2D || CH == 8'h31)) begin : g_bad
      $error("seq_pattern_gen: illegal char at position %0d", gi);
    end
  end

  logic [IW-1:0] idx_q, idx_d;
  logic          out_q, out_d;

  always_comb begin
    idx_d = idx_q;
    out_d = out_q;
    if (idx_q != LAST) begin
      idx_d = idx_q + 1'b1;
      out_d = BITS[idx_d];
    end
`ifdef SEQ_PATTERN_LOOP_EN
    else begin
      idx_d = '0;
      out_d = BITS[0];
    end
`else
    // Without looping the last char is simply held until the next reset.
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      out_q <= BITS[0];
    end else begin
      idx_q <= idx_d;
      out_q <= out_d;
    end
  end

  assign pg.out  = out_q;
  assign pg.idx  = idx_q;
  assign pg.done = (idx_q == LAST);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - randomized reset stimulus with string-level reference model and scoreboard.
module tb_seq_pattern_gen;

  localparam P1    = "_-01-_0--1_";
  localparam int L1  = $bits(P1) / 8;
  localparam int IW1 = $clog2(L1);
  localparam P2    = "-";
  localparam int NCYC = 2000;

  typedef struct {
    int idx1;
    int out1;
    int done1;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.IW(IW1)) pg1 ();
  seq_pattern_gen_if #(.IW(1))   pg2 ();

  seq_pattern_gen #(.PATTERN(P1)) dut1 (.clk(clk), .rst(rst), .pg(pg1));
  seq_pattern_gen #(.PATTERN(P2)) dut2 (.clk(clk), .rst(rst), .pg(pg2));

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  string pat;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Expected char index after n clocks since reset release, then decoded from the string itself.
  function automatic exp_t model(input int n);
    exp_t e;
    int   k;
`ifdef SEQ_PATTERN_LOOP_EN
    k = n % L1;
`else
    k = (n < L1 - 1) ? n : L1 - 1;
`endif
    e.idx1  = k;
    e.out1  = (pat[k] == "-" || pat[k] == "1") ? 1 : 0;
    e.done1 = (k == L1 - 1) ? 1 : 0;
    return e;
  endfunction

  initial begin : stim
    int n;
    logic rst_at_edge;
    pat = P1;
    n = 0;
    for (int c = 0; c < NCYC; c++) begin
      rst_at_edge = rst;
      @(posedge clk);
      #1;
      if (!rst_at_edge) n++;
      if (c < 3) begin
        rst = 1'b1;
      end else if (rst) begin
        if ($urandom_range(1, 0) == 1) rst = 1'b0;
      end else if ($urandom_range(39, 0) == 0) begin
        rst = 1'b1;
      end
      if (rst) n = 0;
      exp_q.push_back(model(n));
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk("p1_idx",  int'(pg1.idx),  e.idx1);
        chk("p1_out",  int'(pg1.out),  e.out1);
        chk("p1_done", int'(pg1.done), e.done1);
        chk("p2_idx",  int'(pg2.idx),  0);
        chk("p2_out",  int'(pg2.out),  1);
        chk("p2_done", int'(pg2.done), 1);
      end
    end
  end

  initial begin : watchdog
    #((NCYC + 20) * 10);
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
